// File: rtl/coeff_bank.sv
// rtl/coeff_bank.sv - Programmable {slope, intercept} coefficient bank with sequential load and registered read
//
// Purpose: holds DEPTH = 2^ADDR_LINES entries of {slope, intercept}. A load
// sequence writes the entries in order through a write stream. Once every entry
// is written the bank is READY, and reads at rd_ptr_i go to the downstream MAC
// through a single-entry valid/ready output register.
//
// Optional feature macro: COEFF_LOAD_CHECKSUM_EN adds checksum_o. This output is
// the XOR of every word accepted during the current load.
//
// Ports:
//   clkn_i         clock, rising edge
//   rstn_i         asynchronous active-low reset
//   load_start_i   restart the load sequence (wins over writes and reads)
//   wr_valid_i     write-stream word valid (used only in LOAD)
//   wr_data_i      {slope, intercept} write word
//   load_done_o    bank fully loaded
//   rd_en_i        read request
//   rd_ptr_i       entry to read
//   rd_ready_o     read request accepted this cycle if rd_en_i=1
//   coeff_valid_o  output register holds data
//   coeff_ready_i  downstream accepts the output
//   slope_o        registered slope
//   intercept_o    registered intercept
//   checksum_o     (COEFF_LOAD_CHECKSUM_EN only) XOR of words in the current load

module coeff_bank #(
    parameter int ADDR_LINES = 4,
    parameter int COEFF_W    = 16
) (
    input  logic                    clkn_i,
    input  logic                    rstn_i,
    input  logic                    load_start_i,
    input  logic                    wr_valid_i,
    input  logic [2*COEFF_W-1:0]    wr_data_i,
    output logic                    load_done_o,
    input  logic                    rd_en_i,
    input  logic [ADDR_LINES-1:0]   rd_ptr_i,
    output logic                    rd_ready_o,
    output logic                    coeff_valid_o,
    input  logic                    coeff_ready_i,
    output logic [COEFF_W-1:0]      slope_o,
    output logic [COEFF_W-1:0]      intercept_o
`ifdef COEFF_LOAD_CHECKSUM_EN
    ,
    output logic [2*COEFF_W-1:0]    checksum_o
`endif
);

    localparam int DEPTH = 1 << ADDR_LINES;
    localparam logic [ADDR_LINES-1:0] LAST_PTR = ADDR_LINES'(DEPTH - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_LINES-1:0]   wr_ptr_q;
    logic [2*COEFF_W-1:0]    mem [DEPTH];
    logic [2*COEFF_W-1:0]    data_q;
    logic                    valid_q;
    logic                    wr_accept;
    logic                    rd_accept;

    // load_start_i overrides any write or read in the same cycle.
    assign wr_accept = (state_q == LOAD) && wr_valid_i && !load_start_i;

    // No path from rd_en_i: the ready flag depends only on state, the output
    // register occupancy, coeff_ready_i and load_start_i.
    assign rd_ready_o = (state_q == READY) && !load_start_i
                        && (!valid_q || coeff_ready_i);
    assign rd_accept  = rd_en_i && rd_ready_o;

    always_ff @(posedge clkn_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load_start_i) begin
            state_d = LOAD;
        end else if (wr_accept && (wr_ptr_q == LAST_PTR)) begin
            state_d = READY;
        end
    end

    // The write pointer wraps to 0 after the last entry. It is ignored until
    // the next load_start_i.
    always_ff @(posedge clkn_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
        end else if (load_start_i) begin
            wr_ptr_q <= '0;
        end else if (wr_accept) begin
            wr_ptr_q <= wr_ptr_q + ADDR_LINES'(1);
        end
    end

    // Coefficient storage is not reset; its contents only matter after a full load.
    always_ff @(posedge clkn_i) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

    // Single-entry output register. On a drain with no new read, the data is
    // kept and only valid drops.
    always_ff @(posedge clkn_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_start_i) begin
            valid_q <= 1'b0;
        end else if (rd_accept) begin
            valid_q <= 1'b1;
            data_q  <= mem[rd_ptr_i];
        end else if (coeff_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign load_done_o   = (state_q == READY);
    assign coeff_valid_o = valid_q;
    assign slope_o       = data_q[2*COEFF_W-1:COEFF_W];
    assign intercept_o   = data_q[COEFF_W-1:0];

`ifdef COEFF_LOAD_CHECKSUM_EN
    logic [2*COEFF_W-1:0] checksum_q;

    always_ff @(posedge clkn_i or negedge rstn_i) begin
        if (!rstn_i) begin
            checksum_q <= '0;
        end else if (load_start_i) begin
            checksum_q <= '0;
        end else if (wr_accept) begin
            checksum_q <= checksum_q ^ wr_data_i;
        end
    end

    assign checksum_o = checksum_q;
`endif

endmodule

// File: tb/tb_coeff_bank.sv
// tb/tb_coeff_bank.sv - Self-checking bench for coeff_bank

module tb_coeff_bank;

    logic        clkn_i;
    logic        rstn_i;
    logic        load_start_i;
    logic        wr_valid_i;
    logic [31:0] wr_data_i;
    logic        load_done_o;
    logic        rd_en_i;
    logic [3:0]  rd_ptr_i;
    logic        rd_ready_o;
    logic        coeff_valid_o;
    logic        coeff_ready_i;
    logic [15:0] slope_o;
    logic [15:0] intercept_o;
`ifdef COEFF_LOAD_CHECKSUM_EN
    logic [31:0] checksum_o;
`endif

    int          n_pass;
    int          n_total;
    logic [31:0] csum_model;

    coeff_bank #(.ADDR_LINES(4), .COEFF_W(16)) dut (
        .clkn_i        (clkn_i),
        .rstn_i        (rstn_i),
        .load_start_i  (load_start_i),
        .wr_valid_i    (wr_valid_i),
        .wr_data_i     (wr_data_i),
        .load_done_o   (load_done_o),
        .rd_en_i       (rd_en_i),
        .rd_ptr_i      (rd_ptr_i),
        .rd_ready_o    (rd_ready_o),
        .coeff_valid_o (coeff_valid_o),
        .coeff_ready_i (coeff_ready_i),
        .slope_o       (slope_o),
        .intercept_o   (intercept_o)
`ifdef COEFF_LOAD_CHECKSUM_EN
        ,
        .checksum_o    (checksum_o)
`endif
    );

    initial clkn_i = 1'b0;
    always #5 clkn_i = ~clkn_i;

    typedef struct {
        logic        rd_en;
        logic [3:0]  ptr;
        logic        cready;
        logic        exp_rdy;
        logic        exp_valid;
        logic [15:0] exp_slope;
        logic [15:0] exp_icpt;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clkn_i);
        #1;
    endtask

    task automatic do_load_start();
        load_start_i = 1'b1;
        tick();
        load_start_i = 1'b0;
        csum_model   = '0;
    endtask

    task automatic write_word(input logic [31:0] d);
        wr_valid_i = 1'b1;
        wr_data_i  = d;
        tick();
        wr_valid_i = 1'b0;
        csum_model = csum_model ^ d;
    endtask

    task automatic read_check(input logic [3:0] ptr, input logic [31:0] exp, input string name);
        rd_en_i       = 1'b1;
        rd_ptr_i      = ptr;
        coeff_ready_i = 1'b1;
        #1;
        chk({name, "_rdy"}, {31'd0, rd_ready_o}, 32'd1);
        tick();
        rd_en_i = 1'b0;
        chk({name, "_valid"}, {31'd0, coeff_valid_o}, 32'd1);
        chk({name, "_data"}, {slope_o, intercept_o}, exp);
    endtask

    initial begin
        n_pass        = 0;
        n_total       = 0;
        csum_model    = '0;
        rstn_i        = 1'b0;
        load_start_i  = 1'b0;
        wr_valid_i    = 1'b0;
        wr_data_i     = '0;
        rd_en_i       = 1'b1;
        rd_ptr_i      = 4'd2;
        coeff_ready_i = 1'b1;

        vecs[0] = '{1'b1, 4'd5, 1'b1, 1'b1, 1'b1, 16'h0005, 16'h0105};
        vecs[1] = '{1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 16'h0003, 16'h0103};
        vecs[2] = '{1'b1, 4'd7, 1'b0, 1'b0, 1'b1, 16'h0003, 16'h0103};
        vecs[3] = '{1'b1, 4'd7, 1'b0, 1'b0, 1'b1, 16'h0003, 16'h0103};
        vecs[4] = '{1'b1, 4'd7, 1'b0, 1'b0, 1'b1, 16'h0003, 16'h0103};
        vecs[5] = '{1'b1, 4'd7, 1'b0, 1'b0, 1'b1, 16'h0003, 16'h0103};
        vecs[6] = '{1'b1, 4'd7, 1'b1, 1'b1, 1'b1, 16'h0007, 16'h0107};
        vecs[7] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 16'h0007, 16'h0107};
        vecs[8] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0007, 16'h0107};

        // Reset state
        #3;
        chk("rst_load_done", {31'd0, load_done_o}, 32'd0);
        chk("rst_rd_ready", {31'd0, rd_ready_o}, 32'd0);
        chk("rst_valid", {31'd0, coeff_valid_o}, 32'd0);
        chk("rst_data", {slope_o, intercept_o}, 32'd0);
`ifdef COEFF_LOAD_CHECKSUM_EN
        chk("rst_checksum", checksum_o, 32'd0);
`endif
        @(negedge clkn_i);
        rstn_i = 1'b1;

        // Read in EMPTY is dropped
        #1;
        chk("empty_rd_ready", {31'd0, rd_ready_o}, 32'd0);
        tick();
        chk("empty_valid", {31'd0, coeff_valid_o}, 32'd0);
        rd_en_i = 1'b0;

        // Full load {k, 0x100+k}, with a dropped read after 8 writes
        do_load_start();
        for (int k = 0; k < 16; k++) begin
            if (k == 8) begin
                rd_en_i  = 1'b1;
                rd_ptr_i = 4'd1;
                #1;
                chk("load_rd_ready", {31'd0, rd_ready_o}, 32'd0);
                tick();
                chk("load_valid", {31'd0, coeff_valid_o}, 32'd0);
                rd_en_i = 1'b0;
            end
            if (k == 15) begin
                chk("load_done_before_last", {31'd0, load_done_o}, 32'd0);
            end
            write_word({16'(k), 16'(32'h100 + k)});
        end
        chk("load_done_after_last", {31'd0, load_done_o}, 32'd1);
`ifdef COEFF_LOAD_CHECKSUM_EN
        chk("checksum_first_load", checksum_o, 32'h0000_0000);
`endif

        // Table vectors: first read in first READY cycle, then backpressure and drain
        for (int i = 0; i < 9; i++) begin
            rd_en_i       = vecs[i].rd_en;
            rd_ptr_i      = vecs[i].ptr;
            coeff_ready_i = vecs[i].cready;
            #1;
            chk($sformatf("vec%0d_rdy", i), {31'd0, rd_ready_o}, {31'd0, vecs[i].exp_rdy});
            tick();
            chk($sformatf("vec%0d_valid", i), {31'd0, coeff_valid_o}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_data", i), {slope_o, intercept_o},
                {vecs[i].exp_slope, vecs[i].exp_icpt});
        end
        rd_en_i = 1'b0;

        // Back-to-back reads with no bubbles
        for (int k = 0; k < 16; k++) begin
            read_check(4'(k), {16'(k), 16'(32'h100 + k)}, $sformatf("b2b%0d", k));
        end
        tick();
        chk("b2b_drain_valid", {31'd0, coeff_valid_o}, 32'd0);

        // load_start while valid and a write are both present
        rd_en_i       = 1'b1;
        rd_ptr_i      = 4'd9;
        coeff_ready_i = 1'b0;
        tick();
        chk("pre_restart_valid", {31'd0, coeff_valid_o}, 32'd1);
        load_start_i = 1'b1;
        wr_valid_i   = 1'b1;
        wr_data_i    = 32'hDEAD_BEEF;
        rd_ptr_i     = 4'd4;
        #1;
        chk("restart_rd_ready", {31'd0, rd_ready_o}, 32'd0);
        tick();
        load_start_i = 1'b0;
        wr_valid_i   = 1'b0;
        rd_en_i      = 1'b0;
        csum_model   = '0;
        chk("restart_valid", {31'd0, coeff_valid_o}, 32'd0);
        chk("restart_load_done", {31'd0, load_done_o}, 32'd0);
        write_word(32'hAAAA_5555);
        for (int k = 1; k < 16; k++) begin
            write_word({16'(k), 16'(32'h200 + k)});
        end
        chk("reload_done", {31'd0, load_done_o}, 32'd1);
`ifdef COEFF_LOAD_CHECKSUM_EN
        chk("checksum_reload", checksum_o, csum_model);
`endif
        // Writes in READY are ignored
        write_word(32'h0BAD_0BAD);
        read_check(4'd0, 32'hAAAA_5555, "reload_ptr0");
        read_check(4'd15, 32'h000F_020F, "reload_ptr15");

`ifdef COEFF_LOAD_CHECKSUM_EN
        do_load_start();
        for (int k = 0; k < 15; k++) begin
            write_word(32'hFFFF_FFFF);
        end
        write_word(32'h1234_5678);
        chk("checksum_ff_load", checksum_o, 32'hEDCB_A987);
        tick();
        chk("checksum_stable_ready", checksum_o, 32'hEDCB_A987);
`endif

        // Reset while a read result is held
        rd_en_i       = 1'b1;
        rd_ptr_i      = 4'd2;
        coeff_ready_i = 1'b0;
        tick();
        rd_en_i = 1'b0;
        chk("hold_valid_before_rst", {31'd0, coeff_valid_o}, 32'd1);
        #2;
        rstn_i = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, coeff_valid_o}, 32'd0);
        chk("midrst_load_done", {31'd0, load_done_o}, 32'd0);
        chk("midrst_data", {slope_o, intercept_o}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
